// File: rtl/tb_ctrl_pkg.sv
// Shared constants and types for the testbench control peripheral.
package tb_ctrl_pkg;

  // Register offsets within the 256-byte peripheral window.
  localparam logic [7:0] RegStdout     = 8'h00;
  localparam logic [7:0] RegTestStatus = 8'h04;
  localparam logic [7:0] RegExit       = 8'h08;
  localparam logic [7:0] RegCycles     = 8'h0C;
  localparam logic [7:0] RegStatus     = 8'h10;

  // TEST_STATUS value that firmware writes to report success.
  localparam logic [31:0] PassMagicDefault = 32'd123456789;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StDone
  } ctrl_state_e;

  typedef enum logic [1:0] {
    KindPass,
    KindFail,
    KindExit
  } term_kind_e;

  // Classify a TEST_STATUS write: only the exact magic word counts as a pass.
  function automatic term_kind_e status_kind(logic [31:0] value, logic [31:0] magic);
    return (value == magic) ? KindPass : KindFail;
  endfunction

endpackage

// File: rtl/tb_ctrl_fifo.sv
// Synchronous FIFO for the stdout character stream. DEPTH must be a power of two
// (at least 2) so the read/write pointers wrap naturally.
module tb_ctrl_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/tb_ctrl_periph.sv
// Testbench control peripheral: stdout FIFO, cycle counter and pass/fail/exit
// reporting on the core data bus. Termination is reported only once every queued
// stdout character has left the FIFO.
// Optional macro TB_CTRL_DISPLAY_EN: sim-only console echo, FIFO drains every cycle
// and stdout_ready_i is ignored.
module tb_ctrl_periph
  import tb_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] PASS_MAGIC = PassMagicDefault
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        stdout_valid_o,
  output logic [7:0]  stdout_char_o,
  input  logic        stdout_ready_i,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  // Bus decode
  logic       addr_hit;
  logic [7:0] reg_off;
  logic       wr_stdout_req;
  logic       stall;
  logic       accept_wr;
  logic       term_wr;

  // FIFO interface
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [7:0]      fifo_rdata;
  logic [CntW-1:0] fifo_count;
  logic            sink_ready;

  // Registers
  logic        rvalid_q;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] cycle_q;
  ctrl_state_e state_q, state_d;
  term_kind_e  kind_q, kind_d;
  logic [31:0] code_q, code_d;

  // Byte lanes above 0 and the sub-word address bits carry no information here.
  logic unused_bits;
  assign unused_bits = ^{data_be_i[3:1], data_addr_i[1:0]};

`ifdef TB_CTRL_DISPLAY_EN
  logic unused_ready;
  assign unused_ready = stdout_ready_i;
  assign sink_ready   = 1'b1;
`else
  assign sink_ready   = stdout_ready_i;
`endif

  assign addr_hit = (data_addr_i[31:8] == BASE_ADDR[31:8]);
  assign reg_off  = {data_addr_i[7:2], 2'b00};

  assign fifo_pop = !fifo_empty && sink_ready;

  // A STDOUT write into a full FIFO waits unless the head leaves this same cycle.
  assign wr_stdout_req = data_req_i && data_we_i && addr_hit && (reg_off == RegStdout);
  assign stall         = wr_stdout_req && fifo_full && !fifo_pop;
  assign data_gnt_o    = data_req_i && !stall;

  // Once DONE, the peripheral still answers the bus but ignores every write.
  assign accept_wr = data_gnt_o && data_we_i && addr_hit && (state_q != StDone);
  assign fifo_push = accept_wr && (reg_off == RegStdout) && data_be_i[0];
  assign term_wr   = accept_wr && ((reg_off == RegTestStatus) || (reg_off == RegExit));

  tb_ctrl_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (fifo_push),
    .wdata_i(data_wdata_i[7:0]),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  assign stdout_valid_o = !fifo_empty;
  // Gate the head so the character bus reads 0 whenever nothing is queued.
  assign stdout_char_o  = fifo_empty ? 8'h00 : fifo_rdata;

  // Read data mux, sampled at the grant cycle; writes and misses answer 0.
  always_comb begin
    rdata_d = '0;
    if (data_gnt_o && !data_we_i && addr_hit) begin
      case (reg_off)
        RegCycles: rdata_d = cycle_q;
        RegStatus: rdata_d = {{(32 - CntW - 2){1'b0}}, fifo_count, fifo_full, fifo_empty};
        default:   rdata_d = '0;
      endcase
    end
  end

  // Response channel: one-cycle rvalid pulse after every grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= data_gnt_o;
      rdata_q  <= rdata_d;
    end
  end

  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;

  // Free-running cycle counter; wraps naturally at 32 bits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
    end
  end

  // Termination FSM next-state: first termination write wins, then wait for drain.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    code_d  = code_q;
    unique case (state_q)
      StRun: begin
        if (term_wr) begin
          state_d = StDrain;
          if (reg_off == RegExit) begin
            kind_d = KindExit;
            code_d = data_wdata_i;
          end else begin
            kind_d = status_kind(data_wdata_i, PASS_MAGIC);
          end
        end
      end
      StDrain: begin
        // A push this cycle means a character is still on its way out.
        if (fifo_empty && !fifo_push) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  // Termination FSM registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StRun;
      kind_q  <= KindPass;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      code_q  <= code_d;
    end
  end

  assign tests_passed_o = (state_q == StDone) && (kind_q == KindPass);
  assign tests_failed_o = (state_q == StDone) && (kind_q == KindFail);
  assign exit_valid_o   = (state_q == StDone) && (kind_q == KindExit);
  assign exit_value_o   = exit_valid_o ? code_q : 32'h0;

`ifdef TB_CTRL_DISPLAY_EN
  // Sim-only console echo of each character leaving the FIFO.
  always_ff @(posedge clk_i) begin
    if (fifo_pop) begin
      $write("%c", fifo_rdata);
    end
  end
`endif

endmodule

// File: tb/tb_tb_ctrl_periph.sv
// Randomised self-checking bench for tb_ctrl_periph against a queue-based model.
module tb_tb_ctrl_periph;

  localparam logic [31:0] Base  = 32'h1000_0000;
  localparam int unsigned Depth = 16;
  localparam logic [31:0] Magic = 32'd123456789;

  localparam logic [31:0] OffStdout = 32'h00;
  localparam logic [31:0] OffTest   = 32'h04;
  localparam logic [31:0] OffExit   = 32'h08;
  localparam logic [31:0] OffCycles = 32'h0C;
  localparam logic [31:0] OffStatus = 32'h10;

  logic        clk, rst_n;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  logic        svalid, sready;
  logic [7:0]  schar;
  logic        passed, failed, exitv;
  logic [31:0] exitval;

  int total = 0;
  int bad   = 0;

  byte unsigned exp_q[$];
  byte unsigned got_q[$];
  logic [31:0]  mcnt;

  tb_ctrl_periph #(
    .BASE_ADDR (Base),
    .FIFO_DEPTH(Depth),
    .PASS_MAGIC(Magic)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .data_req_i    (req),
    .data_addr_i   (addr),
    .data_we_i     (we),
    .data_be_i     (be),
    .data_wdata_i  (wdata),
    .data_gnt_o    (gnt),
    .data_rvalid_o (rvalid),
    .data_rdata_o  (rdata),
    .stdout_valid_o(svalid),
    .stdout_char_o (schar),
    .stdout_ready_i(sready),
    .tests_passed_o(passed),
    .tests_failed_o(failed),
    .exit_valid_o  (exitv),
    .exit_value_o  (exitval)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle count: clock edges seen since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mcnt <= 32'h0;
    else        mcnt <= mcnt + 32'h1;
  end

  // Character sink: records every accepted handshake.
  always @(posedge clk) begin
    if (rst_n && svalid === 1'b1 && sready === 1'b1) got_q.push_back(schar);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] status_exp(input int fill);
    logic [31:0] v;
    v = 32'(fill) << 2;
    if (fill == Depth) v = v | 32'h2;
    if (fill == 0)     v = v | 32'h1;
    return v;
  endfunction

  function automatic bit queues_match();
    if (got_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) if (got_q[i] != exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int model_fill();
    return exp_q.size() - got_q.size();
  endfunction

  // One bus transaction; cyc returns the model cycle count at the grant cycle.
  task automatic bus_xfer(input logic [31:0] a, input logic w, input logic [3:0] b,
                          input logic [31:0] d, output logic [31:0] rd,
                          output logic [31:0] cyc);
    int waited;
    @(negedge clk);
    req = 1'b1; addr = a; we = w; be = b; wdata = d;
    #1;
    waited = 0;
    while (gnt !== 1'b1 && waited < 40) begin
      @(negedge clk);
      #1;
      waited++;
    end
    total++;
    if (gnt !== 1'b1) begin
      bad++;
      $display("FAIL bus_grant addr=%h got gnt=%b want 1", a, gnt);
      req = 1'b0; we = 1'b0; rd = 32'h0; cyc = 32'h0;
      return;
    end
    cyc = mcnt;
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0;
    total++;
    if (rvalid !== 1'b1) begin
      bad++;
      $display("FAIL bus_rvalid addr=%h got %b want 1", a, rvalid);
    end
    rd = rdata;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'h0; sready = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    got_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] rd, cyc;
    #12;
    total++;
    if ({rvalid, rdata, svalid, schar, passed, failed, exitv, exitval} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got rvalid=%b rdata=%h sv=%b ch=%h p=%b f=%b e=%b ev=%h want 0",
               rvalid, rdata, svalid, schar, passed, failed, exitv, exitval);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus_xfer(Base | OffStatus, 1'b0, 4'hF, 32'h0, rd, cyc);
    total++;
    if (rd !== 32'h1) begin bad++; $display("FAIL reset_status got %h want %h", rd, 32'h1); end
    bus_xfer(Base | OffCycles, 1'b0, 4'hF, 32'h0, rd, cyc);
    total++;
    if (rd !== cyc) begin bad++; $display("FAIL reset_cycles got %h want %h", rd, cyc); end
  endtask

  task automatic test_hi();
    logic [31:0] rd, cyc;
    apply_reset();
    sready = 1'b0;
    bus_xfer(Base | OffStdout, 1'b1, 4'h1, 32'h48, rd, cyc);
    exp_q.push_back(8'h48);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL hi_write_rdata got %h want 0", rd); end
    @(posedge clk);
    #1;
    total++;
    if (rvalid !== 1'b0) begin bad++; $display("FAIL hi_rvalid_pulse got %b want 0", rvalid); end
    bus_xfer(Base | OffStdout, 1'b1, 4'h1, 32'h69, rd, cyc);
    exp_q.push_back(8'h69);
    total++;
    if (svalid !== 1'b1 || schar !== 8'h48) begin
      bad++;
      $display("FAIL hi_head got v=%b c=%h want v=1 c=48", svalid, schar);
    end
    bus_xfer(Base | OffStatus, 1'b0, 4'hF, 32'h0, rd, cyc);
    total++;
    if (rd !== status_exp(2)) begin bad++; $display("FAIL hi_status2 got %h want %h", rd, status_exp(2)); end
    @(negedge clk);
    sready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (!queues_match()) begin
      bad++;
      $display("FAIL hi_chars got n=%0d want n=%0d", got_q.size(), exp_q.size());
    end
    bus_xfer(Base | OffStatus, 1'b0, 4'hF, 32'h0, rd, cyc);
    total++;
    if (rd !== status_exp(0)) begin bad++; $display("FAIL hi_status0 got %h want %h", rd, status_exp(0)); end
  endtask

  task automatic test_full();
    logic [31:0] rd, cyc;
    byte unsigned c;
    int stalled;
    apply_reset();
    sready = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      c = 8'($urandom);
      bus_xfer(Base | OffStdout, 1'b1, 4'h1, {24'($urandom), c}, rd, cyc);
      exp_q.push_back(c);
    end
    bus_xfer(Base | OffStatus, 1'b0, 4'hF, 32'h0, rd, cyc);
    total++;
    if (rd !== status_exp(Depth)) begin
      bad++; $display("FAIL full_status got %h want %h", rd, status_exp(Depth));
    end
    c = 8'($urandom);
    @(negedge clk);
    req = 1'b1; we = 1'b1; be = 4'h1; addr = Base | OffStdout; wdata = {24'h0, c};
    stalled = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (gnt === 1'b0) stalled++;
      @(negedge clk);
    end
    total++;
    if (stalled != 4) begin bad++; $display("FAIL full_stall got %0d stalled cycles want 4", stalled); end
    sready = 1'b1;
    #1;
    total++;
    if (gnt !== 1'b1) begin bad++; $display("FAIL full_pop_grant got %b want 1", gnt); end
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0; sready = 1'b0;
    exp_q.push_back(c);
    total++;
    if (rvalid !== 1'b1) begin bad++; $display("FAIL full_rvalid got %b want 1", rvalid); end
    bus_xfer(Base | OffStatus, 1'b0, 4'hF, 32'h0, rd, cyc);
    total++;
    if (rd !== status_exp(model_fill())) begin
      bad++; $display("FAIL full_status2 got %h want %h", rd, status_exp(model_fill()));
    end
    sready = 1'b1;
    repeat (Depth + 4) @(posedge clk);
    #1;
    total++;
    if (!queues_match()) begin
      bad++; $display("FAIL full_chars got n=%0d want n=%0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_pass_drain();
    logic [31:0] rd, cyc;
    byte unsigned c;
    int waited;
    apply_reset();
    sready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      c = 8'($urandom);
      bus_xfer(Base | OffStdout, 1'b1, 4'h1, {24'h0, c}, rd, cyc);
      exp_q.push_back(c);
    end
    bus_xfer(Base | OffTest, 1'b1, 4'hF, Magic, rd, cyc);
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (passed !== 1'b0) begin bad++; $display("FAIL pass_held got %b want 0", passed); end
    @(negedge clk);
    sready = 1'b1;
    waited = 0;
    do begin
      @(posedge clk);
      #1;
      waited++;
    end while (svalid === 1'b1 && waited < 10);
    total++;
    if (svalid !== 1'b0) begin bad++; $display("FAIL pass_drain got valid=%b want 0", svalid); end
    total++;
    if (passed !== 1'b0) begin bad++; $display("FAIL pass_early got %b want 0", passed); end
    @(posedge clk);
    #1;
    total++;
    if (passed !== 1'b1) begin bad++; $display("FAIL pass_rise got %b want 1", passed); end
    // DONE: writes are ignored, reads are still served.
    bus_xfer(Base | OffStdout, 1'b1, 4'h1, 32'h58, rd, cyc);
    bus_xfer(Base | OffTest, 1'b1, 4'hF, 32'h0, rd, cyc);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({passed, failed, exitv, svalid} !== 4'b1000) begin
      bad++; $display("FAIL pass_hold got p=%b f=%b e=%b v=%b want 1000", passed, failed, exitv, svalid);
    end
    bus_xfer(Base | OffStatus, 1'b0, 4'hF, 32'h0, rd, cyc);
    total++;
    if (rd !== status_exp(0)) begin bad++; $display("FAIL pass_status got %h want %h", rd, status_exp(0)); end
    total++;
    if (!queues_match()) begin
      bad++; $display("FAIL pass_chars got n=%0d want n=%0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_exit();
    logic [31:0] rd, cyc;
    apply_reset();
    bus_xfer(Base | OffExit, 1'b1, 4'hF, 32'd5, rd, cyc);
    bus_xfer(Base | OffTest, 1'b1, 4'hF, Magic, rd, cyc);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({exitv, passed, failed} !== 3'b100 || exitval !== 32'd5) begin
      bad++;
      $display("FAIL exit_first got e=%b p=%b f=%b val=%0d want e=1 p=0 f=0 val=5",
               exitv, passed, failed, exitval);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, cyc, a, expv;
    logic [3:0]  b;
    byte unsigned c;
    int fill, op;
    logic w;
    apply_reset();
    for (int it = 0; it < 80; it++) begin
      fill = model_fill();
      sready = (fill >= Depth) ? 1'b1 : 1'($urandom_range(0, 1));
      op = $urandom_range(0, 6);
      case (op)
        0, 1, 2: begin
          c = 8'($urandom);
          b = 4'($urandom);
          bus_xfer(Base | OffStdout, 1'b1, b, {24'($urandom), c}, rd, cyc);
          if (b[0]) exp_q.push_back(c);
          total++;
          if (rd !== 32'h0) begin bad++; $display("FAIL rnd_wr_rdata got %h want 0", rd); end
        end
        3: begin
          expv = status_exp(fill);
          bus_xfer(Base | OffStatus, 1'b0, 4'hF, 32'h0, rd, cyc);
          total++;
          if (rd !== expv) begin bad++; $display("FAIL rnd_status got %h want %h", rd, expv); end
        end
        4: begin
          bus_xfer(Base | OffCycles, 1'b0, 4'hF, 32'h0, rd, cyc);
          total++;
          if (rd !== cyc) begin bad++; $display("FAIL rnd_cycles got %h want %h", rd, cyc); end
        end
        5: begin
          a = Base | (32'h14 + 32'(4 * $urandom_range(0, 58)));
          w = 1'($urandom_range(0, 1));
          bus_xfer(a, w, 4'hF, $urandom, rd, cyc);
          total++;
          if (rd !== 32'h0) begin bad++; $display("FAIL rnd_unmapped addr=%h got %h want 0", a, rd); end
        end
        default: begin
          a = 32'h2000_0000 | (32'(4 * $urandom_range(0, 4)));
          w = 1'($urandom_range(0, 1));
          bus_xfer(a, w, 4'hF, w ? Magic : 32'h0, rd, cyc);
          total++;
          if (rd !== 32'h0) begin bad++; $display("FAIL rnd_foreign addr=%h got %h want 0", a, rd); end
        end
      endcase
    end
    sready = 1'b1;
    repeat (Depth + 4) @(posedge clk);
    #1;
    total++;
    if (!queues_match()) begin
      bad++; $display("FAIL rnd_chars got n=%0d want n=%0d", got_q.size(), exp_q.size());
    end
    total++;
    if ({passed, failed, exitv} !== 3'b000) begin
      bad++; $display("FAIL rnd_no_term got p=%b f=%b e=%b want 000", passed, failed, exitv);
    end
  endtask

  task automatic test_cycles();
    logic [31:0] r1, r2, r3, cyc;
    bus_xfer(Base | OffCycles, 1'b0, 4'hF, 32'h0, r1, cyc);
    total++;
    if (r1 !== cyc) begin bad++; $display("FAIL cyc_abs got %h want %h", r1, cyc); end
    repeat (9) @(posedge clk);
    bus_xfer(Base | OffCycles, 1'b0, 4'hF, 32'h0, r2, cyc);
    total++;
    if (r2 - r1 !== 32'd10) begin bad++; $display("FAIL cyc_delta got %0d want 10", r2 - r1); end
    @(negedge clk);
    force dut.cycle_q = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_q;
    repeat (3) @(posedge clk);
    bus_xfer(Base | OffCycles, 1'b0, 4'hF, 32'h0, r3, cyc);
    total++;
    if (r3 !== 32'h1) begin bad++; $display("FAIL cyc_wrap got %h want 1", r3); end
  endtask

  task automatic test_reset_drain();
    logic [31:0] rd, cyc;
    byte unsigned c;
    apply_reset();
    sready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c = 8'($urandom);
      bus_xfer(Base | OffStdout, 1'b1, 4'h1, {24'h0, c}, rd, cyc);
      exp_q.push_back(c);
    end
    bus_xfer(Base | OffTest, 1'b1, 4'hF, Magic, rd, cyc);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (svalid !== 1'b1 || passed !== 1'b0) begin
      bad++; $display("FAIL rstd_drain got v=%b p=%b want v=1 p=0", svalid, passed);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({rvalid, rdata, svalid, schar, passed, failed, exitv, exitval} !== '0) begin
      bad++;
      $display("FAIL rstd_outputs got sv=%b ch=%h p=%b f=%b e=%b ev=%h want 0",
               svalid, schar, passed, failed, exitv, exitval);
    end
    exp_q.delete();
    got_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus_xfer(Base | OffStatus, 1'b0, 4'hF, 32'h0, rd, cyc);
    total++;
    if (rd !== status_exp(0)) begin bad++; $display("FAIL rstd_status got %h want %h", rd, status_exp(0)); end
    bus_xfer(Base | OffTest, 1'b1, 4'hF, 32'h0000_0BAD, rd, cyc);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({failed, passed, exitv} !== 3'b100) begin
      bad++; $display("FAIL rstd_fail got f=%b p=%b e=%b want 100", failed, passed, exitv);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'h0; sready = 1'b0;
    test_reset();
    test_hi();
    test_full();
    test_pass_drain();
    test_exit();
    test_random();
    test_cycles();
    test_reset_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
